// File: rtl/if_stage_if.sv
// if_stage_if: fetch-stage bundle carrying the imem read port, EXE redirect and IF->ID handshake.
interface if_stage_if;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        br_jmp_flag;
  logic [31:0] br_target;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [63:0] if_id_bus_out;
  modport master (
    output imem_en, imem_addr, fs_to_ds_valid, if_id_bus_out,
    input  imem_rdata, br_jmp_flag, br_target, ds_allowin
  );
  modport slave (
    input  imem_en, imem_addr, fs_to_ds_valid, if_id_bus_out,
    output imem_rdata, br_jmp_flag, br_target, ds_allowin
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: PC owner issuing 1-cycle imem reads, redirecting on br_jmp_flag and holding the IF->ID bus on stall.
// IF_SKID_BUF_EN: gate imem reads while stalled and keep the fetched word in a skid buffer instead of re-reading.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic       clk,
  input logic       rst_n,
  if_stage_if.master fs
);
  localparam logic [31:0] NOP = 32'h0000_0033;
  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic [31:0] next_pc, inst;
  logic        fs_allowin;
  always_comb begin
    fs_allowin = !fs_valid_q || fs.ds_allowin || fs.br_jmp_flag;
    next_pc    = fs.br_jmp_flag ? {fs.br_target[31:2], 2'b00} : fs_pc_q + 32'd4;
    fs_valid_d = fs_valid_q || fs_allowin;
    fs_pc_d    = fs_allowin ? next_pc : fs_pc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs_valid_q <= 1'b0;
      fs_pc_q    <= RESET_PC - 32'd4;
    end else begin
      fs_valid_q <= fs_valid_d;
      fs_pc_q    <= fs_pc_d;
    end
  end
`ifdef IF_SKID_BUF_EN
  logic        inst_buf_valid_q, inst_buf_valid_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        stall_first;
  always_comb begin
    stall_first      = fs_valid_q && !fs.ds_allowin && !fs.br_jmp_flag && !inst_buf_valid_q;
    inst_buf_d       = stall_first ? fs.imem_rdata : inst_buf_q;
    inst_buf_valid_d = (fs.br_jmp_flag || (fs_valid_q && fs.ds_allowin)) ? 1'b0 : (stall_first || inst_buf_valid_q);
    fs.imem_en       = rst_n && fs_allowin;
    inst             = inst_buf_valid_q ? inst_buf_q : fs.imem_rdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_buf_valid_q <= 1'b0;
      inst_buf_q       <= '0;
    end else begin
      inst_buf_valid_q <= inst_buf_valid_d;
      inst_buf_q       <= inst_buf_d;
    end
  end
`else
  // Without a buffer the stalled PC is re-read every cycle so imem_rdata stays current.
  always_comb begin
    fs.imem_en = rst_n;
    inst       = fs.imem_rdata;
  end
`endif
  always_comb begin
    fs.imem_addr      = fs_allowin ? next_pc : fs_pc_q;
    fs.fs_to_ds_valid = fs_valid_q && !fs.br_jmp_flag;
    fs.if_id_bus_out  = {fs_valid_q ? inst : NOP, fs_pc_q};
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized scoreboard bench for if_stage against a program-stream reference model.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0033;
  typedef struct packed {
    logic        valid;
    logic [63:0] bus;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic        started;
  logic [31:0] exp_pc;
  if_stage_if b0();
  if_stage_if b1();
  if_stage #(.RESET_PC(32'h0000_0000)) u0 (.clk(clk), .rst_n(rst_n), .fs(b0.master));
  if_stage #(.RESET_PC(32'hFFFF_FFFC)) u1 (.clk(clk), .rst_n(rst_n), .fs(b1.master));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction
  // Disabled reads return garbage so a missing hold is visible.
  always @(posedge clk) begin
    b0.imem_rdata <= b0.imem_en ? mem_f(b0.imem_addr) : $urandom();
    b1.imem_rdata <= b1.imem_en ? mem_f(b1.imem_addr) : $urandom();
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("fs_to_ds_valid", {63'd0, b0.fs_to_ds_valid}, {63'd0, mon_e.valid});
      if (mon_e.valid) check("if_id_bus", b0.if_id_bus_out, mon_e.bus);
    end
  end
  // The next PC to be offered advances by 4 per accepted transfer and jumps on redirect.
  task automatic drive(input logic allow, input logic br, input logic [31:0] tgt);
    exp_t e;
    b0.ds_allowin  = allow;
    b0.br_jmp_flag = br;
    b0.br_target   = tgt;
    e.valid = started && !br;
    e.bus   = {mem_f(exp_pc), exp_pc};
    exp_q.push_back(e);
    if (br) exp_pc = {tgt[31:2], 2'b00};
    else if (started && allow) exp_pc = exp_pc + 32'd4;
    started = 1'b1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cyc(input logic allow, input logic br, input logic [31:0] tgt);
    drive(allow, br, tgt);
    tick();
  endtask
  initial begin
    b0.ds_allowin = 1'b0; b0.br_jmp_flag = 1'b0; b0.br_target = '0;
    b1.ds_allowin = 1'b1; b1.br_jmp_flag = 1'b0; b1.br_target = '0;
    started = 1'b0;
    exp_pc  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst imem_en", {63'd0, b0.imem_en}, 64'd0);
    check("rst imem_addr", {32'd0, b0.imem_addr}, 64'd0);
    check("rst valid", {63'd0, b0.fs_to_ds_valid}, 64'd0);
    check("rst bus", b0.if_id_bus_out, {NOP, 32'hFFFF_FFFC});
    check("rst bus hi", b1.if_id_bus_out, {NOP, 32'hFFFF_FFF8});
    check("rst addr hi", {32'd0, b1.imem_addr}, {32'd0, 32'hFFFF_FFFC});
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 32'h0);
    #1;
    check("c0 imem_en", {63'd0, b0.imem_en}, 64'd1);
    check("c0 imem_addr", {32'd0, b0.imem_addr}, 64'd0);
    check("c0 addr hi", {32'd0, b1.imem_addr}, {32'd0, 32'hFFFF_FFFC});
    tick();
    check("hi c1 valid", {63'd0, b1.fs_to_ds_valid}, 64'd1);
    check("hi c1 bus", b1.if_id_bus_out, {mem_f(32'hFFFF_FFFC), 32'hFFFF_FFFC});
    cyc(1'b1, 1'b0, 32'h0);
    check("hi c2 bus", b1.if_id_bus_out, {mem_f(32'h0), 32'h0});
    cyc(1'b1, 1'b0, 32'h0);
    repeat (3) cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h40);
    repeat (2) cyc(1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 32'h83);
    #1;
    check("redir stall addr", {32'd0, b0.imem_addr}, {32'd0, 32'h80});
    check("redir stall en", {63'd0, b0.imem_en}, 64'd1);
    tick();
    repeat (2) cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h100);
    cyc(1'b1, 1'b1, 32'h200);
    repeat (3) cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (4) cyc(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(3) != 0, $urandom_range(7) == 0, $urandom());
    cyc(1'b0, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst valid", {63'd0, b0.fs_to_ds_valid}, 64'd0);
    check("async rst bus", b0.if_id_bus_out, {NOP, 32'hFFFF_FFFC});
    check("async rst en", {63'd0, b0.imem_en}, 64'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    started = 1'b0;
    exp_pc  = 32'h0;
    repeat (4) cyc(1'b1, 1'b0, 32'h0);
    repeat (2) tick();
    check("queue drained", {32'd0, exp_q.size()}, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
